// File: rtl/jtframe_mixer_seq.sv
// Sequential N-channel stereo mixer: snapshot, one shared multiply-accumulate per channel per cen,
// then scale by the 4 fractional gain bits and saturate. Optional gain slewing and held clip flag.
module jtframe_mixer_seq #(
   parameter int CH        = 4,
   parameter int W         = 16,
   parameter int WOUT      = 16,
   parameter int GW        = 8,
   parameter int RAMP      = 0,
   parameter int PEAK_HOLD = 8
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cen,
   input  logic                   sample_in,
   input  logic [CH*W-1:0]        ch_l,
   input  logic [CH*W-1:0]        ch_r,
   input  logic [CH*GW-1:0]       gain,
   input  logic [CH-1:0]          mute,
   output logic signed [WOUT-1:0] mixed_l,
   output logic signed [WOUT-1:0] mixed_r,
   output logic                   sample_out,
   output logic                   busy,
   output logic                   peak,
   output logic                   overrun
);

   localparam int PW   = W + GW + 1;
   localparam int ACCW = PW + $clog2(CH);
   localparam int IW   = (CH > 1) ? $clog2(CH) : 1;
   localparam int PCW  = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(CH - 1);
   localparam logic signed [ACCW-1:0] SMAX = ACCW'((64'sd1 <<< (WOUT - 1)) - 64'sd1);
   localparam logic signed [ACCW-1:0] SMIN = ACCW'(-(64'sd1 <<< (WOUT - 1)));

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT} state_t;

   state_t                r_state;
   logic [IW-1:0]         r_idx;
   logic signed [W-1:0]   r_snap_l [CH];
   logic signed [W-1:0]   r_snap_r [CH];
   logic signed [ACCW-1:0] r_acc_l, r_acc_r;
   logic [GW-1:0]         r_gain_cur [CH];
   logic [PCW-1:0]        r_pk_cnt;

   logic [GW-1:0]         w_tgt [CH];
   logic [GW-1:0]         w_g;
   logic signed [GW:0]    w_gs;
   logic signed [PW-1:0]  w_prod_l, w_prod_r;
   logic signed [ACCW-1:0] w_sh_l, w_sh_r;
   logic                  w_clip;

   function automatic logic f_clip(input logic signed [ACCW-1:0] v);
      return (v > SMAX) || (v < SMIN);
   endfunction

   function automatic logic signed [WOUT-1:0] f_sat(input logic signed [ACCW-1:0] v);
      if (v > SMAX)      return {1'b0, {(WOUT-1){1'b1}}};
      else if (v < SMIN) return {1'b1, {(WOUT-1){1'b0}}};
      else               return v[WOUT-1:0];
   endfunction

   // Gain is read live each channel step, so gain/mute changes land on the next channel read
   always_comb begin
      for (int k = 0; k < CH; k++)
         w_tgt[k] = mute[k] ? '0 : gain[k*GW +: GW];
      w_g      = (RAMP != 0) ? r_gain_cur[r_idx] : w_tgt[r_idx];
      w_gs     = signed'({1'b0, w_g});
      w_prod_l = PW'(r_snap_l[r_idx]) * PW'(w_gs);
      w_prod_r = PW'(r_snap_r[r_idx]) * PW'(w_gs);
      w_sh_l   = r_acc_l >>> 4;
      w_sh_r   = r_acc_r >>> 4;
      w_clip   = f_clip(w_sh_l) | f_clip(w_sh_r);
   end

   always_ff @(posedge clk) begin
      if (cen && sample_in && r_state == S_IDLE) begin
         for (int k = 0; k < CH; k++) begin
            r_snap_l[k] <= ch_l[k*W +: W];
            r_snap_r[k] <= ch_r[k*W +: W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_acc_l    <= '0;
         r_acc_r    <= '0;
         r_pk_cnt   <= '0;
         mixed_l    <= '0;
         mixed_r    <= '0;
         sample_out <= 1'b0;
         busy       <= 1'b0;
         peak       <= 1'b0;
         overrun    <= 1'b0;
         for (int k = 0; k < CH; k++)
            r_gain_cur[k] <= '0;
      end else begin
         sample_out <= 1'b0;
         overrun    <= 1'b0;
         if (cen) begin
            overrun <= sample_in & busy;
            case (r_state)
               S_IDLE: begin
                  if (sample_in) begin
                     r_state <= S_ACC;
                     r_idx   <= '0;
                     r_acc_l <= '0;
                     r_acc_r <= '0;
                     busy    <= 1'b1;
                  end
               end
               S_ACC: begin
                  r_acc_l <= r_acc_l + ACCW'(w_prod_l);
                  r_acc_r <= r_acc_r + ACCW'(w_prod_r);
                  if (r_idx == IDX_LAST) r_state <= S_SAT;
                  else                   r_idx   <= r_idx + IW'(1);
               end
               S_SAT: begin
                  mixed_l    <= f_sat(w_sh_l);
                  mixed_r    <= f_sat(w_sh_r);
                  sample_out <= 1'b1;
                  busy       <= 1'b0;
                  r_state    <= S_IDLE;
                  // Counter reloads on clip; peak drops once it has counted down to zero
                  if (w_clip) begin
                     r_pk_cnt <= PCW'(PEAK_HOLD);
                     peak     <= 1'b1;
                  end else if (r_pk_cnt != '0) begin
                     r_pk_cnt <= r_pk_cnt - PCW'(1);
                     peak     <= (r_pk_cnt != PCW'(1));
                  end else begin
                     peak     <= 1'b0;
                  end
                  if (RAMP != 0) begin
                     for (int k = 0; k < CH; k++) begin
                        if (r_gain_cur[k] < w_tgt[k])      r_gain_cur[k] <= r_gain_cur[k] + GW'(1);
                        else if (r_gain_cur[k] > w_tgt[k]) r_gain_cur[k] <= r_gain_cur[k] - GW'(1);
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtframe_mixer_seq.sv
// Directed bench for jtframe_mixer_seq: one instance without gain ramp, one with ramp,
// sharing stimulus; expected mixes are hand-computed constants.
module tb_jtframe_mixer_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b1;
   logic        sample_in = 1'b0;
   logic [63:0] ch_l = '0, ch_r = '0;
   logic [31:0] gain = '0;
   logic [3:0]  mute = '0;

   logic [15:0] mixed_l0, mixed_r0, mixed_l1, mixed_r1;
   logic        sample_out0, busy0, peak0, overrun0;
   logic        sample_out1, busy1, peak1, overrun1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jtframe_mixer_seq #(.CH(4), .W(16), .WOUT(16), .GW(8), .RAMP(0), .PEAK_HOLD(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .sample_in(sample_in),
      .ch_l(ch_l), .ch_r(ch_r), .gain(gain), .mute(mute),
      .mixed_l(mixed_l0), .mixed_r(mixed_r0), .sample_out(sample_out0),
      .busy(busy0), .peak(peak0), .overrun(overrun0));

   jtframe_mixer_seq #(.CH(4), .W(16), .WOUT(16), .GW(8), .RAMP(1), .PEAK_HOLD(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .sample_in(sample_in),
      .ch_l(ch_l), .ch_r(ch_r), .gain(gain), .mute(mute),
      .mixed_l(mixed_l1), .mixed_r(mixed_r1), .sample_out(sample_out1),
      .busy(busy1), .peak(peak1), .overrun(overrun1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      ch_l = '0; ch_r = '0; gain = '0; mute = '0;
   endtask

   // One pass; stall inserts cen=0 cycles right after the accept edge
   task automatic pass(input int stall);
      int n;
      sample_in = 1'b1;
      tick();
      sample_in = 1'b0;
      chk("busy_start", 32'(busy0), 32'h1);
      n = 0;
      if (stall > 0) begin
         cen = 1'b0;
         repeat (stall) tick();
         cen = 1'b1;
         n = stall;
      end
      while (!sample_out0 && n < 40) begin
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'(5 + stall));
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_mixl", 32'(mixed_l0), 32'h0);
      chk("rst_mixr", 32'(mixed_r0), 32'h0);
      chk("rst_sout", 32'(sample_out0), 32'h0);
      chk("rst_busy", 32'(busy0), 32'h0);
      chk("rst_peak", 32'(peak0), 32'h0);
      chk("rst_ovr",  32'(overrun0), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Unity gain single channel
      clr();
      ch_l[15:0] = 16'h1000; gain[7:0] = 8'h10;
      pass(0);
      chk("unity_l", 32'(mixed_l0), 32'h1000);
      chk("unity_r", 32'(mixed_r0), 32'h0);
      chk("unity_peak", 32'(peak0), 32'h0);
      tick();
      chk("sout_pulse", 32'(sample_out0), 32'h0);
      chk("busy_end", 32'(busy0), 32'h0);

      // cen gaps stretch latency in clocks but not in cen ticks
      pass(3);
      chk("stall_l", 32'(mixed_l0), 32'h1000);

      // Four-channel weighted sum
      clr();
      ch_l[15:0]  = 16'h0100; gain[7:0]   = 8'h10;
      ch_l[31:16] = 16'h0200; gain[15:8]  = 8'h20;
      ch_l[47:32] = 16'hFF00; gain[23:16] = 8'h08;
      ch_l[63:48] = 16'h0010; gain[31:24] = 8'hFF;
      ch_r[15:0]  = 16'h0800;
      pass(0);
      chk("sum4_l", 32'(mixed_l0), 32'h057F);
      chk("sum4_r", 32'(mixed_r0), 32'h0800);
      mute[0] = 1'b1;
      pass(0);
      chk("mute0_l", 32'(mixed_l0), 32'h047F);
      chk("mute0_r", 32'(mixed_r0), 32'h0);

      // Positive clip and peak hold
      clr();
      ch_l[15:0] = 16'h7000; ch_l[31:16] = 16'h7000; gain[15:0] = 16'h1010;
      pass(0);
      chk("clip_pos", 32'(mixed_l0), 32'h7FFF);
      chk("clip_peak", 32'(peak0), 32'h1);
      clr();
      for (int p = 1; p <= 8; p++) begin
         pass(0);
         chk("peak_hold", 32'(peak0), (p < 8) ? 32'h1 : 32'h0);
      end

      // Negative clip, then floor of -0.5 LSB
      clr();
      ch_r[15:0] = 16'hA000; ch_r[31:16] = 16'hA000; gain[15:0] = 16'h1818;
      pass(0);
      chk("clip_neg", 32'(mixed_r0), 32'h8000);
      chk("clip_neg_peak", 32'(peak0), 32'h1);
      clr();
      ch_r[15:0] = 16'hFFFF; gain[7:0] = 8'h08;
      pass(0);
      chk("floor_m1", 32'(mixed_r0), 32'hFFFF);

      // Overrun during ACC and on the SAT tick
      clr();
      ch_l[15:0] = 16'h1000; gain[7:0] = 8'h10;
      sample_in = 1'b1; tick(); sample_in = 1'b0;
      tick(); tick();
      ch_l[15:0] = 16'h2000; sample_in = 1'b1;
      tick();
      sample_in = 1'b0;
      chk("ovr_acc", 32'(overrun0), 32'h1);
      chk("ovr_nosout", 32'(sample_out0), 32'h0);
      tick();
      chk("ovr_pulse", 32'(overrun0), 32'h0);
      sample_in = 1'b1;
      tick();
      chk("ovr_sout", 32'(sample_out0), 32'h1);
      chk("ovr_sat", 32'(overrun0), 32'h1);
      chk("ovr_snap", 32'(mixed_l0), 32'h1000);
      sample_in = 1'b0;
      tick();
      chk("ovr_notaken", 32'(busy0), 32'h0);

      // Reset at ACC idx=2 aborts the pass
      sample_in = 1'b1; tick(); sample_in = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("arst_mixl", 32'(mixed_l0), 32'h0);
      chk("arst_busy", 32'(busy0), 32'h0);
      chk("arst_peak", 32'(peak0), 32'h0);
      repeat (4) tick();
      chk("arst_nosout", 32'(sample_out0), 32'h0);
      rst_n = 1'b1;
      tick();
      pass(0);
      chk("arst_after", 32'(mixed_l0), 32'h2000);

      // Gain ramp from reset, then mute ramp-down
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      clr();
      ch_l[15:0] = 16'h0100; gain[7:0] = 8'h10;
      for (int n = 1; n <= 18; n++) begin
         pass(0);
         chk("ramp_up", 32'(mixed_l1), 32'(16 * ((n - 1 < 16) ? n - 1 : 16)));
      end
      mute[0] = 1'b1;
      for (int m = 1; m <= 18; m++) begin
         pass(0);
         chk("ramp_dn", 32'(mixed_l1), 32'(16 * ((17 - m > 0) ? 17 - m : 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
